box_shifter: RTL and testbench

Generates the race course of left/right boxes and presents the next box to the player stage. Holds a DEPTH-box window filled from a 16-bit LFSR. Advances one box per rising edge of the player's `correctkey`, and counts down the boxes remaining until the finish line. Sits directly upstream of the player stage (drives its `box` input) and consumes its `correctkey` output.

---
 rtl/pyon_pkg.sv | 20 ++
 rtl/lfsr16.sv | 36 +++
 rtl/box_shifter.sv | 140 ++++++++++++++
 tb/tb_box_shifter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pyon_pkg.sv
// Shared types and constants for the race-course box generator: FSM states,
// LFSR geometry (16-bit Fibonacci, taps 0/2/3/5) and the default seed.
package pyon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int                LFSR_W       = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] l);
    return ^(l & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when a bit is consumed.
// out_bit is the current LSB, i.e. the bit handed out by the next step.
module lfsr16
  import pyon_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic              out_bit
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] seed_eff;

  // An all-zero state would lock the register, so it is mapped to 1.
  assign seed_eff = (seed == '0) ? LFSR_W'(1) : seed;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_feedback(lfsr_q), lfsr_q[LFSR_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= seed_eff;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out_bit = lfsr_q[0];

endmodule

// File: rtl/box_shifter.sv
// Race-course window of left/right boxes, advanced once per correctkey rising edge.
// Define BOX_SHIFTER_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module box_shifter
  import pyon_pkg::*;
#(
  parameter  int                DEPTH     = 8,
  parameter  int                TRACK_LEN = 64,
  parameter  logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  localparam int                REM_W     = $clog2(TRACK_LEN + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             enable,
  input  logic             correctkey,
  output logic             box,
  output logic [DEPTH-1:0] boxes,
  output logic [REM_W-1:0] remaining,
  output logic             running,
  output logic             finished,
  output logic             advance
);

  localparam int CNT_W = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   boxes_q, boxes_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic               advance_q, advance_d;
  logic               delay_q;
  logic               key_s;
  logic               key_edge;
  logic               consume;
  logic               lfsr_bit;

`ifdef BOX_SHIFTER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= correctkey;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;
`else
  assign key_s = correctkey;
`endif

  // The delay flop follows the key unconditionally so a held key never re-fires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      delay_q <= 1'b0;
    end else begin
      delay_q <= key_s;
    end
  end

  assign key_edge = key_s & ~delay_q;

  lfsr16 u_lfsr (
    .clk     (clk),
    .resetn  (resetn),
    .seed    (SEED),
    .step    (consume),
    .out_bit (lfsr_bit)
  );

  always_comb begin
    state_d     = state_q;
    boxes_d     = boxes_q;
    remaining_d = remaining_q;
    fill_cnt_d  = fill_cnt_q;
    advance_d   = 1'b0;
    consume     = 1'b0;

    if (start) begin
      state_d     = ST_FILL;
      boxes_d     = '0;
      remaining_d = REM_W'(TRACK_LEN);
      fill_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          consume    = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d    = ST_RUN;
            fill_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (key_edge && enable && (remaining_q != '0)) begin
            consume     = 1'b1;
            remaining_d = remaining_q - REM_W'(1);
            advance_d   = 1'b1;
            if (remaining_q == REM_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (consume) begin
      boxes_d = {lfsr_bit, boxes_q[DEPTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      boxes_q     <= '0;
      remaining_q <= '0;
      fill_cnt_q  <= '0;
      advance_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boxes_q     <= boxes_d;
      remaining_q <= remaining_d;
      fill_cnt_q  <= fill_cnt_d;
      advance_q   <= advance_d;
    end
  end

  assign box       = boxes_q[0];
  assign boxes     = boxes_q;
  assign remaining = remaining_q;
  assign running   = (state_q == ST_RUN);
  assign finished  = (state_q == ST_DONE);
  assign advance   = advance_q;

endmodule

// File: tb/tb_box_shifter.sv
// Randomized bench for box_shifter against a queue-based course model.
// Honors BOX_SHIFTER_SYNC_EN to model the extra key latency.
module tb_box_shifter;

  localparam int DEPTH     = 8;
  localparam int TRACK_LEN = 64;
  localparam int REM_W     = 7;
`ifdef BOX_SHIFTER_SYNC_EN
  localparam int KEY_LAT = 2;
`else
  localparam int KEY_LAT = 0;
`endif

  logic             clk        = 1'b0;
  logic             resetn     = 1'b1;
  logic             start      = 1'b0;
  logic             enable     = 1'b0;
  logic             correctkey = 1'b0;
  logic             box;
  logic [DEPTH-1:0] boxes;
  logic [REM_W-1:0] remaining;
  logic             running;
  logic             finished;
  logic             advance;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  box_shifter #(
    .DEPTH     (DEPTH),
    .TRACK_LEN (TRACK_LEN),
    .SEED      (16'hACE1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .enable     (enable),
    .correctkey (correctkey),
    .box        (box),
    .boxes      (boxes),
    .remaining  (remaining),
    .running    (running),
    .finished   (finished),
    .advance    (advance)
  );

  // Course model: window as a queue (index 0 = next box), a bit source,
  // a phase number (0 idle, 1 fill, 2 run, 3 done) and a key history.
  logic [15:0] m_lfsr;
  bit          m_win[$];
  int          m_phase;
  int          m_fill;
  int          m_rem;
  bit          m_adv;
  logic [3:0]  k_hist;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit next_course_bit();
    bit b;
    bit fb;
    b      = m_lfsr[0];
    fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
    m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
    return b;
  endfunction

  task automatic model_clear_window();
    m_win.delete();
    for (int i = 0; i < DEPTH; i++) m_win.push_back(1'b0);
  endtask

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_phase = 0;
    m_fill  = 0;
    m_rem   = 0;
    m_adv   = 1'b0;
    k_hist  = '0;
    model_clear_window();
  endtask

  task automatic model_consume();
    void'(m_win.pop_front());
    m_win.push_back(next_course_bit());
  endtask

  function automatic logic [DEPTH-1:0] model_window();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_win[i];
    return v;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".boxes"},     32'(boxes),     32'(model_window()));
    check({ctx, ".box"},       32'(box),       32'(m_win[0]));
    check({ctx, ".remaining"}, 32'(remaining), 32'(m_rem));
    check({ctx, ".running"},   32'(running),   32'(m_phase == 2));
    check({ctx, ".finished"},  32'(finished),  32'(m_phase == 3));
    check({ctx, ".advance"},   32'(advance),   32'(m_adv));
  endtask

  task automatic tick(input string ctx);
    bit key_rise;
    @(posedge clk);
    k_hist   = {k_hist[2:0], correctkey};
    key_rise = k_hist[KEY_LAT] && !k_hist[KEY_LAT+1];
    m_adv    = 1'b0;
    if (start) begin
      m_phase = 1;
      m_fill  = 0;
      m_rem   = TRACK_LEN;
      model_clear_window();
    end else if (m_phase == 1) begin
      model_consume();
      m_fill++;
      if (m_fill == DEPTH) m_phase = 2;
    end else if (m_phase == 2 && key_rise && enable) begin
      model_consume();
      m_rem--;
      m_adv = 1'b1;
      if (m_rem == 0) m_phase = 3;
    end
    #1;
    check_all(ctx);
  endtask

  task automatic press(input string ctx, input int high_cycles, input int low_cycles);
    correctkey = 1'b1;
    repeat (high_cycles) tick(ctx);
    correctkey = 1'b0;
    repeat (low_cycles) tick(ctx);
  endtask

  initial begin
    model_reset();
    #2 resetn = 1'b0;
    #10;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;
    tick("idle");

    // Fill from the seed
    start = 1'b1;
    tick("start");
    start = 1'b0;
    repeat (DEPTH) tick("fill");
    check("fill_window", 32'(boxes), 32'h0000_00E1);
    check("fill_remaining", 32'(remaining), 32'd64);
    $display("fill: boxes=%02h remaining=%0d running=%0b", boxes, remaining, running);

    // One held press: exactly one shift
    enable = 1'b1;
    press("hold3", 3, 3);
    check("hold3_window", 32'(boxes), 32'h0000_0070);
    check("hold3_remaining", 32'(remaining), 32'd63);
    $display("hold3: boxes=%02h remaining=%0d", boxes, remaining);

    // Press while disabled, then enable while still held
    enable = 1'b0;
    press("disabled", 2, 3);
    correctkey = 1'b1;
    repeat (4) tick("held_pre_en");
    enable = 1'b1;
    repeat (4) tick("held_post_en");
    check("held_no_shift", 32'(remaining), 32'd63);
    correctkey = 1'b0;
    repeat (3) tick("release");
    press("repress", 2, 3);
    check("repress_shift", 32'(remaining), 32'd62);
    $display("enable: remaining=%0d", remaining);

    // Run the course to the finish line and beyond
    for (int i = 0; i < 65; i++) press("course", 2, 2);
    check("done_finished", 32'(finished), 32'd1);
    check("done_remaining", 32'(remaining), 32'd0);
    check("done_running", 32'(running), 32'd0);
    $display("done: finished=%0b remaining=%0d", finished, remaining);

    // Restart, then start coinciding with a detected edge in RUN
    start = 1'b1;
    tick("restart");
    start = 1'b0;
    repeat (DEPTH) tick("refill");
    press("refill_press", 2, 2);
    correctkey = 1'b1;
    repeat (KEY_LAT) tick("coinc_pre");
    start = 1'b1;
    tick("coinc");
    start = 1'b0;
    check("coinc_remaining", 32'(remaining), 32'd64);
    check("coinc_advance", 32'(advance), 32'd0);
    correctkey = 1'b0;
    repeat (DEPTH) tick("coinc_fill");
    $display("coinc: boxes=%02h remaining=%0d", boxes, remaining);

    // Asynchronous reset in the middle of FILL
    start = 1'b1;
    tick("mid_start");
    start = 1'b0;
    repeat (3) tick("mid_fill");
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    tick("post_reset_idle");
    start = 1'b1;
    tick("post_reset_start");
    start = 1'b0;
    repeat (DEPTH) tick("post_reset_fill");
    check("post_reset_window", 32'(boxes), 32'h0000_00E1);
    $display("reset: boxes=%02h", boxes);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) correctkey = ~correctkey;
      enable = ($urandom_range(0, 9) != 0);
      start  = ($urandom_range(0, 299) == 0);
      tick("rand");
    end
    start = 1'b0;
    $display("random: remaining=%0d running=%0b finished=%0b", remaining, running, finished);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
